// File: rtl/dtw_subseq_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dtw_subseq_array
// Purpose  : Systolic dynamic-time-warping engine. A query of runtime length
//            qlen (<= MAX_QLEN) is held one sample per PE while a reference
//            stream of any length flows through the array. Supports global
//            and subsequence (free-start) DTW, emits the last-row score per
//            reference column, tracks the best score and a threshold hit.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start, mode, qlen, ref_len, threshold - job control (latched)
//            q_data/q_valid/q_ready - query sample stream
//            r_data/r_valid/r_ready - reference sample stream
//            score/score_valid - D(qlen,j) per reference column
//            busy, done        - job status
//            min_val, min_pos  - best last-row score and its 1-based column
//            hit, hit_pos      - first column whose score <= threshold
// Revision : 1.0 - initial release
// ============================================================================
module dtw_subseq_array #(
  parameter int WIDTH    = 16,
  parameter int MAX_QLEN = 250,
  parameter int QLEN_W   = 8,
  parameter int POS_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [QLEN_W-1:0] qlen,
  input  logic [POS_W-1:0]  ref_len,
  input  logic [WIDTH-1:0]  threshold,
  input  logic [WIDTH-1:0]  q_data,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [WIDTH-1:0]  r_data,
  input  logic              r_valid,
  output logic              r_ready,
  output logic [WIDTH-1:0]  score,
  output logic              score_valid,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  min_val,
  output logic [POS_W-1:0]  min_pos,
  output logic              hit,
  output logic [POS_W-1:0]  hit_pos
);

  localparam logic [WIDTH-1:0]  c_sat      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  c_zero     = '0;
  localparam logic [QLEN_W-1:0] c_max_qlen = QLEN_W'(MAX_QLEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic [QLEN_W-1:0]  r_qlen;
  logic [POS_W-1:0]   r_ref_len;
  logic [WIDTH-1:0]   r_thr;
  logic [QLEN_W-1:0]  r_load_cnt;
  logic [POS_W-1:0]   r_ref_cnt;
  logic [QLEN_W-1:0]  r_drain_cnt;
  logic [POS_W-1:0]   r_out_col;
  logic               r_first;   // next accepted beat is reference column 1

  // Per-PE state: query sample, reference sample in flight, D(i,j) of the
  // last column computed, the upstream value seen one column earlier (the
  // diagonal term), and a valid tag travelling with each real column.
  logic [WIDTH-1:0] r_q  [1:MAX_QLEN];
  logic [WIDTH-1:0] r_y  [1:MAX_QLEN];
  logic [WIDTH-1:0] r_d  [1:MAX_QLEN];
  logic [WIDTH-1:0] r_dp [1:MAX_QLEN];
  logic             r_v  [1:MAX_QLEN];

  logic [WIDTH-1:0] w_new [1:MAX_QLEN];
  logic [WIDTH-1:0] w_top1;
  logic [WIDTH-1:0] w_diag1;
  logic             w_go;
  logic             w_accept;
  logic             w_step;
  logic             w_emit;
  logic [WIDTH-1:0] w_last_d;
  logic             w_last_v;
  logic [POS_W-1:0] w_col;
  logic [POS_W-1:0] w_ref_nxt;
  logic [QLEN_W-1:0] w_load_nxt;

  function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? c_sat : s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  assign w_go       = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept   = (r_state == S_RUN) && r_valid;
  // A stalled RUN cycle freezes the whole array; DRAIN steps unconditionally.
  assign w_step     = w_accept || (r_state == S_DRAIN);
  assign w_col      = r_out_col + POS_W'(1);
  assign w_ref_nxt  = r_ref_cnt + POS_W'(1);
  assign w_load_nxt = r_load_cnt + QLEN_W'(1);

  // Row-0 boundary feeding PE 1. Subsequence mode lets a match start at any
  // column; global mode only allows the origin D(0,0) = 0 on the diagonal.
  assign w_top1  = r_mode ? c_zero : c_sat;
  assign w_diag1 = (r_mode || r_first) ? c_zero : c_sat;

  always_comb begin
    w_new[1] = sat_add(abs_diff(r_q[1], r_data), min3(w_top1, r_d[1], w_diag1));
    for (int i = 2; i <= MAX_QLEN; i++) begin
      w_new[i] = sat_add(abs_diff(r_q[i], r_y[i-1]),
                         min3(r_d[i-1], r_d[i], r_dp[i]));
    end
  end

  // Select the PE holding the last query row.
  always_comb begin
    w_last_d = c_sat;
    w_last_v = 1'b0;
    for (int i = 1; i <= MAX_QLEN; i++) begin
      if (r_qlen == QLEN_W'(i)) begin
        w_last_d = r_d[i];
        w_last_v = r_v[i];
      end
    end
  end

  // Last-row value is emitted on the step that moves it out of the final PE,
  // so a stall in RUN delays the pulse along with everything else.
  assign w_emit = w_step && w_last_v;

  // --------------------------------------------------------------------------
  // Systolic array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= MAX_QLEN; i++) begin
        r_q[i]  <= '0;
        r_y[i]  <= '0;
        r_d[i]  <= c_sat;
        r_dp[i] <= c_sat;
        r_v[i]  <= 1'b0;
      end
    end else begin
      if (w_go) begin
        for (int i = 1; i <= MAX_QLEN; i++) begin
          r_d[i]  <= c_sat;
          r_dp[i] <= c_sat;
          r_v[i]  <= 1'b0;
        end
      end else if (w_step) begin
        r_v[1] <= w_accept;
        r_y[1] <= r_data;
        if (w_accept) begin
          r_d[1] <= w_new[1];
        end
        for (int i = 2; i <= MAX_QLEN; i++) begin
          r_v[i] <= r_v[i-1];
          r_y[i] <= r_y[i-1];
          // Only real columns update a PE, so its diagonal register always
          // holds the upstream value of the previous real column.
          if (r_v[i-1]) begin
            r_d[i]  <= w_new[i];
            r_dp[i] <= r_d[i-1];
          end
        end
      end

      if ((r_state == S_LOAD) && q_valid) begin
        for (int i = 1; i <= MAX_QLEN; i++) begin
          if (r_load_cnt == QLEN_W'(i - 1)) begin
            r_q[i] <= q_data;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and result tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_qlen      <= '0;
      r_ref_len   <= '0;
      r_thr       <= '0;
      r_load_cnt  <= '0;
      r_ref_cnt   <= '0;
      r_drain_cnt <= '0;
      r_out_col   <= '0;
      r_first     <= 1'b0;
      q_ready     <= 1'b0;
      r_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      score       <= '0;
      score_valid <= 1'b0;
      min_val     <= c_sat;
      min_pos     <= '0;
      hit         <= 1'b0;
      hit_pos     <= '0;
    end else begin
      score_valid <= 1'b0;

      if (w_emit) begin
        score       <= w_last_d;
        score_valid <= 1'b1;
        r_out_col   <= w_col;
        if (r_mode) begin
          // Strict compare keeps the earliest column on ties.
          if (w_last_d < min_val) begin
            min_val <= w_last_d;
            min_pos <= w_col;
          end
        end else begin
          // Global result is simply the final column; track the latest.
          min_val <= w_last_d;
          min_pos <= w_col;
        end
        if (!hit && (w_last_d <= r_thr)) begin
          hit     <= 1'b1;
          hit_pos <= w_col;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mode     <= mode;
            r_qlen     <= (qlen > c_max_qlen) ? c_max_qlen : qlen;
            r_ref_len  <= ref_len;
            r_thr      <= threshold;
            r_load_cnt <= '0;
            r_ref_cnt  <= '0;
            r_out_col  <= '0;
            r_first    <= 1'b1;
            min_val    <= c_sat;
            min_pos    <= '0;
            hit        <= 1'b0;
            hit_pos    <= '0;
            if ((qlen == '0) || (ref_len == '0)) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              q_ready <= 1'b1;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end
        end

        S_LOAD: begin
          if (q_valid) begin
            r_load_cnt <= w_load_nxt;
            if (w_load_nxt == r_qlen) begin
              r_state <= S_RUN;
              q_ready <= 1'b0;
              r_ready <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (r_valid) begin
            r_ref_cnt <= w_ref_nxt;
            r_first   <= 1'b0;
            if (w_ref_nxt == r_ref_len) begin
              r_state     <= S_DRAIN;
              r_ready     <= 1'b0;
              r_drain_cnt <= r_qlen;
            end
          end
        end

        S_DRAIN: begin
          r_drain_cnt <= r_drain_cnt - QLEN_W'(1);
          if (r_drain_cnt == QLEN_W'(1)) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtw_subseq_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dtw_subseq_array
// Purpose  : Scoreboard bench for dtw_subseq_array with hand-computed vectors.
//            The reference driver queues expected scores; a negedge monitor
//            pops and compares them, along with per-column latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtw_subseq_array;

  localparam int W  = 8;
  localparam int MQ = 8;
  localparam int QW = 8;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [QW-1:0] qlen;
  logic [PW-1:0] ref_len;
  logic [W-1:0]  threshold;
  logic [W-1:0]  q_data;
  logic          q_valid;
  logic          q_ready;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_ready;
  logic [W-1:0]  score;
  logic          score_valid;
  logic          busy;
  logic          done;
  logic [W-1:0]  min_val;
  logic [PW-1:0] min_pos;
  logic          hit;
  logic [PW-1:0] hit_pos;

  dtw_subseq_array #(
    .WIDTH(W), .MAX_QLEN(MQ), .QLEN_W(QW), .POS_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .qlen(qlen),
    .ref_len(ref_len), .threshold(threshold),
    .q_data(q_data), .q_valid(q_valid), .q_ready(q_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .score(score), .score_valid(score_valid), .busy(busy), .done(done),
    .min_val(min_val), .min_pos(min_pos), .hit(hit), .hit_pos(hit_pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] score;
    bit           last;
  } exp_t;

  typedef struct {
    int cyc;
    int stalls;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];

  int tests     = 0;
  int fails     = 0;
  int ncyc      = 0;
  int stall_cnt = 0;
  int cur_qlen  = 0;

  logic [W-1:0] qs [8];
  logic [W-1:0] rs [8];
  logic [W-1:0] es [8];

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops one expected score per score_valid pulse and checks that
  // the pulse arrived qlen cycles plus intervening stalls after its beat.
  exp_t mon_e;
  acc_t mon_a;
  always @(negedge clk) begin
    if (score_valid) begin
      check("score_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("score", score, mon_e.score);
        check("accept_record", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          mon_a = acc_q.pop_front();
          check("latency", ncyc - mon_a.cyc - 1,
                cur_qlen + stall_cnt - mon_a.stalls);
        end
        if (mon_e.last) check("done_with_last_score", done, 1);
      end
    end
    if (r_ready && r_valid) acc_q.push_back('{ncyc, stall_cnt});
    if (r_ready && !r_valid) stall_cnt++;
    ncyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input bit is_q);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (is_q ? q_ready : r_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    check(is_q ? "q_handshake" : "r_handshake", ok, 1);
  endtask

  task automatic start_job(input bit m, input int ql, input int rl, input int thr);
    mode      = m;
    qlen      = QW'(ql);
    ref_len   = PW'(rl);
    threshold = W'(thr);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic load_query(input int ql, input int gapmax);
    for (int i = 0; i < ql; i++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      q_valid = 1'b0;
      repeat (g) tick();
      q_valid = 1'b1;
      q_data  = qs[i];
      handshake(1'b1);
    end
    q_valid = 1'b0;
  endtask

  task automatic send_ref(input int n, input int gapmax, input bit push);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      r_valid = 1'b0;
      repeat (g) tick();
      r_valid = 1'b1;
      r_data  = rs[i];
      if (push) exp_q.push_back('{es[i], (i == n - 1)});
      handshake(1'b0);
    end
    r_valid = 1'b0;
  endtask

  task automatic wait_done_check(input int mv, input int mp, input int h, input int hp);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    check("done_reached", ok, 1);
    check("busy_at_done", busy, 0);
    check("min_val", min_val, mv);
    check("min_pos", min_pos, mp);
    check("hit", hit, h);
    check("hit_pos", hit_pos, hp);
    tick();
    check("scores_outstanding", exp_q.size(), 0);
  endtask

  task automatic run_full(input bit m, input int ql, input int rl, input int thr,
                          input int qgap, input int rgap,
                          input int mv, input int mp, input int h, input int hp);
    cur_qlen = ql;
    start_job(m, ql, rl, thr);
    load_query(ql, qgap);
    send_ref(rl, rgap, 1'b1);
    wait_done_check(mv, mp, h, hp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_q_ready"},     q_ready, 0);
    check({tag, "_r_ready"},     r_ready, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_done"},        done, 0);
    check({tag, "_score_valid"}, score_valid, 0);
    check({tag, "_hit"},         hit, 0);
    check({tag, "_score"},       score, 0);
    check({tag, "_min_val"},     min_val, 255);
    check({tag, "_min_pos"},     min_pos, 0);
    check({tag, "_hit_pos"},     hit_pos, 0);
  endtask

  task automatic zero_len_job(input string tag, input int ql, input int rl);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    start_job(1'b1, ql, rl, 1);
    check({tag, "_done"},    done, 1);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_min_val"}, min_val, 255);
    check({tag, "_min_pos"}, min_pos, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({tag, "_ready_idle"}, q_ready | r_ready, 0);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    qlen      = '0;
    ref_len   = '0;
    threshold = '0;
    q_data    = '0;
    q_valid   = 1'b0;
    r_data    = '0;
    r_valid   = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Subsequence DTW, query {1,2,3}, reference {0,1,2,3,9}.
    qs = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    rs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd9, 8'd0, 8'd0, 8'd0};
    es = '{8'd6, 8'd3, 8'd1, 8'd0, 8'd6, 8'd0, 8'd0, 8'd0};
    run_full(1'b1, 3, 5, 1, 0, 0, 0, 4, 1, 3);

    // Global DTW, same data.
    es = '{8'd6, 8'd4, 8'd2, 8'd1, 8'd7, 8'd0, 8'd0, 8'd0};
    run_full(1'b0, 3, 5, 1, 0, 0, 7, 5, 1, 4);

    // Subsequence again with random query and reference gaps.
    es = '{8'd6, 8'd3, 8'd1, 8'd0, 8'd6, 8'd0, 8'd0, 8'd0};
    run_full(1'b1, 3, 5, 1, 2, 3, 0, 4, 1, 3);

    // Saturation: every cell pinned at MAX.
    qs = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    rs = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    es = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_full(1'b0, 2, 2, 254, 0, 0, 255, 2, 0, 0);

    // Degenerate lengths complete immediately.
    zero_len_job("qlen0", 0, 5);
    zero_len_job("reflen0", 3, 0);

    // Reset in the middle of RUN, then rerun the first job.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    qs = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    rs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd9, 8'd0, 8'd0, 8'd0};
    cur_qlen = 3;
    start_job(1'b1, 3, 5, 1);
    load_query(3, 0);
    send_ref(2, 0, 1'b0);
    check("busy_mid_run", busy, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrun_reset");
    acc_q.delete();
    rst = 1'b0;
    tick();
    es = '{8'd6, 8'd3, 8'd1, 8'd0, 8'd6, 8'd0, 8'd0, 8'd0};
    run_full(1'b1, 3, 5, 1, 0, 0, 0, 4, 1, 3);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dtw_subseq_array.md
# dtw_subseq_array

Parametrised systolic DTW engine, successor to the fixed-length squiggle-vs-reference core. Adds a runtime query length up to `MAX_QLEN`, valid/ready streaming for query and reference with back-pressure-safe stalling, selectable global or subsequence (free-start) DTW, a per-column last-row score stream, and a threshold-hit detector. It sits between the squiggle loader and the match-reporting logic. One query is held in the array while a reference of any length streams through.

## Interface
- `WIDTH`, 16: sample and score width. All scores saturate at `2^WIDTH-1` (MAX).
- `MAX_QLEN`, 250: number of PEs, which is the maximum query length.
- `QLEN_W`, 8: width of `qlen`. Must satisfy `2^QLEN_W > MAX_QLEN`.
- `POS_W`, 32: width of reference length and position fields.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a job. Sampled only in IDLE or DONE.
- `mode` in 1: 0 = global DTW, 1 = subsequence DTW. Latched on `start`.
- `qlen` in QLEN_W: query length. Latched on `start`.
- `ref_len` in POS_W: reference length. Latched on `start`.
- `threshold` in WIDTH: hit threshold. Latched on `start`.
- `q_data` in WIDTH, `q_valid` in 1, `q_ready` out 1: query sample stream.
- `r_data` in WIDTH, `r_valid` in 1, `r_ready` out 1: reference sample stream.
- `score` out WIDTH, `score_valid` out 1: D(qlen,j), emitted once per reference column j.
- `busy` out 1: high in LOAD, RUN and DRAIN.
- `done` out 1: high in DONE.
- `min_val` out WIDTH, `min_pos` out POS_W: best last-row score and its 1-based column.
- `hit` out 1, `hit_pos` out POS_W: sticky flag and column of the first D(qlen,j) ≤ threshold.

## Operation
- **Reset values:** state IDLE; `q_ready`, `r_ready`, `busy`, `done`, `score_valid`, `hit` all 0; `score` 0; `min_val` MAX; `min_pos` 0; `hit_pos` 0. All PE cells are MAX and all query registers are 0.
- **IDLE/DONE, on `start`:**
  - Latch the job inputs.
  - Clamp `qlen` to `MAX_QLEN`.
  - Clear `min_val`, `min_pos`, `hit`, `hit_pos` and all PE cells to their reset values.
  - Go to LOAD.
  - If qlen = 0 or ref_len = 0, go directly to DONE instead, with `min_val` = MAX and `min_pos` = 0.
- **LOAD:**
  - `q_ready` = 1.
  - Each `q_valid` beat writes query register i = 1, 2, … in order.
  - After beat number qlen, go to RUN.
- **RUN:**
  - `r_ready` = 1.
  - The array advances one step only on a cycle with `r_valid` = 1. With `r_valid` = 0 the array holds all state; no bubble is inserted.
  - After beat number ref_len, go to DRAIN.
- **DRAIN:**
  - `r_ready` = 0.
  - The array advances one step every cycle, for qlen cycles, then goes to DONE.
- **DONE:**
  - Results hold until the next `start`.
  - `start` in any other state is ignored.
- **Recurrence**, with x_i = query sample and y_j = reference sample:
  - D(i,j) = |x_i − y_j| + min(D(i−1,j), D(i,j−1), D(i−1,j−1)).
  - The cost is unsigned absolute difference. The addition saturates at MAX.
- **Boundaries:**
  - D(i,0) = MAX for i ≥ 1.
  - Global mode: D(0,0) = 0 and D(0,j) = MAX for j ≥ 1.
  - Subsequence mode: D(0,j) = 0 for all j.
- **Systolic schedule:** PE i computes column j on the step after PE i−1 computed column j. The reference sample and the PE's previous-step value shift one PE per step. PEs with i > qlen are don't-care.
- **Last-row results:**
  - Each D(qlen,j) pulses `score_valid` for one cycle, with j ascending.
  - Subsequence mode: on each pulse, update `min_val`/`min_pos` if score < `min_val`. The comparison is strict, so the earliest column wins a tie.
  - Global mode: `min_val` = D(qlen, ref_len) and `min_pos` = ref_len.
  - In both modes: on the first pulse with score ≤ threshold, set `hit` = 1 and `hit_pos` = j. Later pulses do not change them.
- **Reset mid-job:** `rst` in any state returns to the reset values on the next edge. A partial job leaves no residue.

## Timing
- Without stalls, `score` for column j is valid exactly qlen cycles after reference beat j is accepted. Each RUN stall cycle delays this by one cycle.
- `done` rises qlen cycles after the final reference beat. `min_val`, `min_pos`, `hit` and `hit_pos` are final on that same cycle.
- `q_ready` and `r_ready` are registered state decodes and do not depend on `q_valid` or `r_valid`.
- Throughput is one reference column per cycle. A job costs qlen + ref_len + qlen cycles plus stall cycles.

## Test plan
- Subsequence mode, query {1,2,3}, reference {0,1,2,3,9}, threshold 1:
  - Scores 6,3,1,0,6.
  - `min_val` = 0, `min_pos` = 4.
  - `hit` = 1, `hit_pos` = 3.
- Global mode, same data:
  - Scores 6,4,2,1,7.
  - `min_val` = 7, `min_pos` = 5.
  - `hit` = 1, `hit_pos` = 4.
- The first test repeated with a random `r_valid` gap pattern and `q_valid` gaps:
  - Identical scores and results.
  - Score latency equals qlen cycles plus the stall count.
- WIDTH = 8, global mode, query {0,0}, reference {255,255}, threshold 254:
  - All scores 255 (saturated).
  - `min_val` = 255.
  - `hit` = 0.
- qlen = 0, then ref_len = 0:
  - Each goes IDLE → DONE in one cycle.
  - `min_val` = 255 (MAX at WIDTH = 8), `min_pos` = 0.
  - `q_ready` and `r_ready` are never asserted.
- `rst` asserted mid-RUN, then the first test rerun:
  - All outputs are at their reset values on the cycle after the reset edge.
  - The rerun produces results identical to the first test.
